freq_meter_ctrl: RTL and testbench

FREQ_METER_CTRL -- requirements
Module: freq_meter_ctrl

---
 rtl/freq_meter_ctrl.sv | 128 ++++++++++++
 tb/tb_freq_meter_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_ctrl.sv
// Reciprocal-free frequency meter controller: sequences clear/gate windows for the
// counting datapath, then computes freq = CLK_STAND_FREQ * X / Y with a serial divider.
module freq_meter_ctrl #(
  parameter logic [26:0] CLK_STAND_FREQ = 27'd100_000_000,
  parameter int unsigned GUARD_CYCLES   = 12_500_000,
  parameter int unsigned GATE_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        cont_mode,
  input  logic        abort,
  input  logic        cnt_done,
  input  logic [47:0] cnt_test,
  input  logic [47:0] cnt_stand,
  output logic        gate_s,
  output logic        cnt_clr,
  output logic        busy,
  output logic [33:0] freq,
  output logic        freq_valid,
  output logic        no_signal
);

  typedef enum logic [2:0] {IDLE, PRE, GATE, WAIT, LOAD, DIV, DONE} state_t;

  localparam logic [31:0] GUARD_LAST   = 32'(GUARD_CYCLES - 1);
  localparam logic [31:0] GATE_LAST    = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] DIV_LAST     = 32'd74;
  localparam logic [33:0] FREQ_MAX     = '1;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [47:0] x_q, y_q;
  logic [74:0] pq, pq_nxt, dividend;
  logic [47:0] rem, rem_nxt;
  logic [48:0] trial;
  logic        sub_ok;
  logic [33:0] done_freq;
  logic        done_ns;

  // pq holds the dividend, shifting left while quotient bits enter at the LSB
  assign dividend = 75'(CLK_STAND_FREQ) * 75'(x_q);
  assign trial    = {rem, pq[74]};
  assign sub_ok   = trial >= {1'b0, y_q};
  assign rem_nxt  = sub_ok ? 48'(trial - {1'b0, y_q}) : trial[47:0];
  assign pq_nxt   = {pq[73:0], sub_ok};

  assign busy       = (state != IDLE);
  assign freq_valid = (state == DONE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_freq = '0;
    done_ns   = 1'b0;
    case (state)
      IDLE: if (start || cont_mode) state_nxt = PRE;
      PRE:  if (cnt == GUARD_LAST) state_nxt = GATE;
      GATE: if (cnt == GATE_LAST)  state_nxt = WAIT;
      WAIT: begin
        if (cnt_done) begin
          state_nxt = LOAD;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = DONE;
          done_ns   = 1'b1;
        end
      end
      LOAD: begin
        if (x_q == '0 || y_q == '0) begin
          state_nxt = DONE;
          done_ns   = 1'b1;
        end else begin
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (cnt == DIV_LAST) begin
          state_nxt = DONE;
          done_freq = (pq_nxt[74:34] != '0) ? FREQ_MAX : pq_nxt[33:0];
        end
      end
      DONE:    state_nxt = cont_mode ? PRE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt       <= '0;
      gate_s    <= 1'b0;
      cnt_clr   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      pq        <= '0;
      rem       <= '0;
      freq      <= '0;
      no_signal <= 1'b0;
    end else begin
      cnt     <= (state_nxt != state) ? '0 : cnt + 32'd1;
      gate_s  <= (state_nxt == GATE);
      cnt_clr <= (state_nxt == PRE);
      if (state_nxt == LOAD) begin
        x_q <= cnt_test;
        y_q <= cnt_stand;
      end
      if (state == LOAD) begin
        pq  <= dividend;
        rem <= '0;
      end else if (state == DIV) begin
        pq  <= pq_nxt;
        rem <= rem_nxt;
      end
      if (state_nxt == DONE) begin
        freq      <= done_freq;
        no_signal <= done_ns;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Self-checking bench for freq_meter_ctrl: table vectors, randomized operands against an
// arithmetic reference, and hand sequences for timeout, continuous mode, abort and reset.
module tb_freq_meter_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont_mode = 1'b0;
  logic        abort = 1'b0;
  logic        cnt_done = 1'b0;
  logic [47:0] cnt_test = '0;
  logic [47:0] cnt_stand = '0;
  logic        gate_s, cnt_clr, busy, freq_valid, no_signal;
  logic [33:0] freq;

  localparam logic [33:0] SAT = 34'h3_FFFF_FFFF;

  freq_meter_ctrl #(
    .CLK_STAND_FREQ (27'd100_000_000),
    .GUARD_CYCLES   (10),
    .GATE_CYCLES    (100),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .cont_mode  (cont_mode),
    .abort      (abort),
    .cnt_done   (cnt_done),
    .cnt_test   (cnt_test),
    .cnt_stand  (cnt_stand),
    .gate_s     (gate_s),
    .cnt_clr    (cnt_clr),
    .busy       (busy),
    .freq       (freq),
    .freq_valid (freq_valid),
    .no_signal  (no_signal)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  typedef struct {
    logic [47:0] x;
    logic [47:0] y;
    logic [33:0] f;
    logic        ns;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge sys_clk);
  endtask

  // Reference: exact rational result with floor and saturation, plain wide arithmetic
  task automatic model(input logic [47:0] x, input logic [47:0] y,
                       output logic [33:0] f, output logic ns);
    logic [127:0] p, q;
    if (x == '0 || y == '0) begin
      f  = '0;
      ns = 1'b1;
    end else begin
      p  = 128'(x) * 128'd100_000_000;
      q  = p / 128'(y);
      f  = (q > 128'(SAT)) ? SAT : q[33:0];
      ns = 1'b0;
    end
  endtask

  // Caller sits at the negedge before the edge that enters PRE; returns at first WAIT cycle
  task automatic run_to_wait(input bit noise, input bit drop_cont);
    int n_clr, n_gate;
    tick;
    start = 1'b0;
    n_clr = 0;
    chk("pre_busy", busy, 1);
    chk("pre_gate_low", gate_s, 0);
    while (cnt_clr && n_clr < 1000) begin
      if (noise && n_clr == 3) begin
        cnt_done = 1'b1; cnt_test = 48'd9; cnt_stand = 48'd9;
      end else begin
        cnt_done = 1'b0;
      end
      n_clr++;
      tick;
    end
    cnt_done = 1'b0;
    chk("pre_len", n_clr, 10);
    chk("gate_clr_low", cnt_clr, 0);
    n_gate = 0;
    while (gate_s && n_gate < 1000) begin
      if (noise && n_gate == 50) begin
        cnt_done = 1'b1; start = 1'b1;
      end else begin
        cnt_done = 1'b0; start = 1'b0;
      end
      if (drop_cont && n_gate == 40) cont_mode = 1'b0;
      n_gate++;
      tick;
    end
    cnt_done = 1'b0;
    start = 1'b0;
    chk("gate_len", n_gate, 100);
    chk("wait_busy", busy, 1);
  endtask

  // Caller is at the first WAIT negedge; returns at the freq_valid negedge
  task automatic measure(input logic [47:0] x, input logic [47:0] y,
                         input logic [33:0] ef, input logic ens, input int elat);
    int n;
    cnt_done = 1'b1; cnt_test = x; cnt_stand = y;
    n = 0;
    do begin
      tick;
      cnt_done = 1'b0;
      cnt_test = 48'({$urandom, $urandom});
      cnt_stand = 48'({$urandom, $urandom});
      n++;
    end while (!freq_valid && n < 300);
    chk("latency", n, elat);
    chk("freq", freq, ef);
    chk("no_signal", no_signal, ens);
  endtask

  initial begin
    logic [47:0] rx, ry;
    logic [33:0] mf;
    logic        mns;
    int          n;
    int          n_fv;

    tbl[0] = '{48'd50, 48'd100, 34'd50_000_000, 1'b0, 77};
    tbl[1] = '{48'd0, 48'd5, 34'd0, 1'b1, 2};
    tbl[2] = '{48'd5, 48'd0, 34'd0, 1'b1, 2};
    tbl[3] = '{48'h100_0000_0000, 48'd1, SAT, 1'b0, 77};
    tbl[4] = '{48'd3, 48'd7, 34'd42_857_142, 1'b0, 77};
    tbl[5] = '{48'd1, 48'hFFFF_FFFF_FFFF, 34'd0, 1'b0, 77};
    tbl[6] = '{48'd1, 48'd1, 34'd100_000_000, 1'b0, 77};
    tbl[7] = '{48'd171, 48'd1, 34'd17_100_000_000, 1'b0, 77};
    tbl[8] = '{48'd172, 48'd1, SAT, 1'b0, 77};

    #1;
    chk("rst_freq", freq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gate", gate_s, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_valid", freq_valid, 0);
    chk("rst_nosig", no_signal, 0);
    repeat (3) tick;
    sys_rst_n = 1'b1;
    repeat (3) tick;
    chk("idle_no_start", busy, 0);

    for (int i = 0; i < 9; i++) begin
      start = 1'b1;
      run_to_wait(i == 0, 1'b0);
      measure(tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].ns, tbl[i].lat);
      tick;
      chk("idle_after", busy, 0);
      chk("valid_pulse", freq_valid, 0);
      chk("freq_held", freq, tbl[i].f);
    end

    for (int i = 0; i < 12; i++) begin
      rx = 48'({$urandom, $urandom}) >> $urandom_range(0, 47);
      ry = 48'({$urandom, $urandom}) >> $urandom_range(0, 47);
      if ($urandom_range(0, 7) == 0) rx = '0;
      if ($urandom_range(0, 7) == 0) ry = '0;
      model(rx, ry, mf, mns);
      start = 1'b1;
      run_to_wait(1'b0, 1'b0);
      measure(rx, ry, mf, mns, (rx == '0 || ry == '0) ? 2 : 77);
      tick;
      chk("rnd_idle", busy, 0);
    end

    start = 1'b1;
    run_to_wait(1'b0, 1'b0);
    n = 0;
    do begin
      tick;
      n++;
    end while (!freq_valid && n < 100);
    chk("timeout_lat", n, 20);
    chk("timeout_freq", freq, 0);
    chk("timeout_nosig", no_signal, 1);
    tick;
    chk("timeout_idle", busy, 0);

    cont_mode = 1'b1;
    run_to_wait(1'b0, 1'b0);
    measure(48'd50, 48'd100, 34'd50_000_000, 1'b0, 77);
    run_to_wait(1'b0, 1'b1);
    measure(48'd3, 48'd7, 34'd42_857_142, 1'b0, 77);
    tick;
    chk("cont_drop_idle", busy, 0);
    chk("cont_drop_clr", cnt_clr, 0);

    start = 1'b1;
    run_to_wait(1'b0, 1'b0);
    measure(48'd50, 48'd100, 34'd50_000_000, 1'b0, 77);
    tick;
    start = 1'b1;
    run_to_wait(1'b0, 1'b0);
    cnt_done = 1'b1; cnt_test = 48'd1; cnt_stand = 48'd1;
    tick;
    cnt_done = 1'b0;
    repeat (30) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_div_busy", busy, 0);
    chk("abort_div_gate", gate_s, 0);
    chk("abort_div_clr", cnt_clr, 0);
    chk("abort_div_valid", freq_valid, 0);
    chk("abort_div_freq", freq, 34'd50_000_000);
    n_fv = 0;
    repeat (100) begin
      tick;
      if (freq_valid || busy) n_fv++;
    end
    chk("abort_div_quiet", n_fv, 0);

    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (60) tick;
    chk("pre_abort_gate", gate_s, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_gate_busy", busy, 0);
    chk("abort_gate_gate", gate_s, 0);
    chk("abort_gate_clr", cnt_clr, 0);
    chk("abort_gate_freq", freq, 34'd50_000_000);
    chk("abort_gate_nosig", no_signal, 0);

    abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    chk("abort_vs_start", busy, 0);

    start = 1'b1;
    run_to_wait(1'b0, 1'b0);
    abort = 1'b1; cnt_done = 1'b1; cnt_test = 48'd1; cnt_stand = 48'd1;
    tick;
    abort = 1'b0; cnt_done = 1'b0;
    n_fv = 0;
    repeat (5) begin
      if (freq_valid || busy) n_fv++;
      tick;
    end
    chk("abort_vs_done", n_fv, 0);
    chk("abort_vs_done_freq", freq, 34'd50_000_000);

    start = 1'b1;
    run_to_wait(1'b0, 1'b0);
    cnt_done = 1'b1; cnt_test = 48'd50; cnt_stand = 48'd100;
    tick;
    cnt_done = 1'b0;
    repeat (10) tick;
    sys_rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_freq", freq, 0);
    chk("rstmid_gate", gate_s, 0);
    tick;
    sys_rst_n = 1'b1;
    n_fv = 0;
    repeat (100) begin
      tick;
      if (freq_valid || busy) n_fv++;
    end
    chk("rstmid_idle", n_fv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
